// File: rtl/flip_sequencer_if.sv
// Start/result handshake, board-RAM read port and flipper control for the move sequencer.
// slave is the sequencer side, master is the controller/RAM/flipper side.
interface flip_sequencer_if #(
   parameter int STEP_W = 5
);
   logic              start;
   logic              player;
   logic [6:0]        s_addr_in;
   logic [1:0]        mem_data_in;
   logic              flip_done_in;
   logic [6:0]        mem_addr_o;
   logic              mem_sel_o;
   logic              flip_ld_o;
   logic              flip_en_o;
   logic [6:0]        flip_addr_o;
   logic [STEP_W-1:0] flip_step_o;
   logic              flip_sign_o;
   logic              flip_skip_o;
   logic              busy_o;
   logic              done_o;
   logic              move_valid_o;
   logic [7:0]        dir_mask_o;
   logic [5:0]        flip_count_o;

   modport slave (
      input  start, player, s_addr_in, mem_data_in, flip_done_in,
      output mem_addr_o, mem_sel_o, flip_ld_o, flip_en_o, flip_addr_o, flip_step_o,
             flip_sign_o, flip_skip_o, busy_o, done_o, move_valid_o, dir_mask_o, flip_count_o
   );

   modport master (
      output start, player, s_addr_in, mem_data_in, flip_done_in,
      input  mem_addr_o, mem_sel_o, flip_ld_o, flip_en_o, flip_addr_o, flip_step_o,
             flip_sign_o, flip_skip_o, busy_o, done_o, move_valid_o, dir_mask_o, flip_count_o
   );
endinterface

// File: rtl/flip_sequencer.sv
// Scans the 8 rays from a placement cell, launching the flipper once per capturing ray.
// RAM reads take two edges (address, wait, sample); flips block until flip_done_in.
module flip_sequencer #(
   parameter int NDIR   = 8,
   parameter int STEP_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   flip_sequencer_if.slave   bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_ORG_WAIT, S_ORG_EVAL, S_DIR_INIT, S_STEP, S_READ_WAIT,
      S_EVAL, S_LD_FLIP, S_EN_FLIP, S_WAIT_FLIP, S_NEXT_DIR, S_DONE
   } state_t;

   state_t            state_q;
   logic [6:0]        origin_q;
   logic              player_q;
   logic [2:0]        dir_q;
   logic [2:0]        row_q;
   logic [2:0]        col_q;
   logic [2:0]        run_q;
   logic [6:0]        mem_addr_q;
   logic              sel_q;
   logic              ld_q;
   logic              en_q;
   logic [STEP_W-1:0] step_q;
   logic              sign_q;
   logic              busy_q;
   logic              done_q;
   logic              valid_q;
   logic [7:0]        mask_q;
   logic [5:0]        count_q;

   logic              up, down, left, right, at_edge, dir_sign;
   logic [2:0]        row_d, col_d;
   logic [STEP_W-1:0] dir_step;
   logic [1:0]        own_col, opp_col;

   // Ray geometry from the direction index: d0..d2 go up, d5..d7 go down.
   always_comb begin
      up       = (dir_q <= 3'd2);
      down     = (dir_q >= 3'd5);
      left     = (dir_q == 3'd0) || (dir_q == 3'd3) || (dir_q == 3'd5);
      right    = (dir_q == 3'd2) || (dir_q == 3'd4) || (dir_q == 3'd7);
      at_edge  = (up && row_q == 3'd0) || (down && row_q == 3'd7) ||
                 (left && col_q == 3'd0) || (right && col_q == 3'd7);
      row_d    = row_q;
      col_d    = col_q;
      if (up)         row_d = row_q - 3'd1;
      else if (down)  row_d = row_q + 3'd1;
      if (left)       col_d = col_q - 3'd1;
      else if (right) col_d = col_q + 3'd1;
      if (up || down) dir_step = (left || right) ? ((up == left) ? STEP_W'(9) : STEP_W'(7)) : STEP_W'(8);
      else            dir_step = STEP_W'(1);
      dir_sign = up || (left && !down);
      own_col  = player_q ? 2'b10 : 2'b01;
      opp_col  = player_q ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         origin_q   <= '0;
         player_q   <= 1'b0;
         dir_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         run_q      <= '0;
         mem_addr_q <= '0;
         sel_q      <= 1'b0;
         ld_q       <= 1'b0;
         en_q       <= 1'b0;
         step_q     <= '0;
         sign_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         mask_q     <= '0;
         count_q    <= '0;
      end else begin
         ld_q   <= 1'b0;
         en_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  origin_q <= bus.s_addr_in;
                  player_q <= bus.player;
                  mask_q   <= '0;
                  count_q  <= '0;
                  valid_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  if (bus.s_addr_in[6]) begin
                     state_q <= S_DONE;
                  end else begin
                     mem_addr_q <= bus.s_addr_in;
                     state_q    <= S_ORG_WAIT;
                  end
               end
            end
            S_ORG_WAIT: state_q <= S_ORG_EVAL;
            S_ORG_EVAL: begin
               if (bus.mem_data_in != 2'b00) begin
                  state_q <= S_DONE;
               end else begin
                  dir_q   <= '0;
                  state_q <= S_DIR_INIT;
               end
            end
            S_DIR_INIT: begin
               row_q   <= origin_q[5:3];
               col_q   <= origin_q[2:0];
               run_q   <= '0;
               state_q <= S_STEP;
            end
            S_STEP: begin
               if (at_edge) begin
                  state_q <= S_NEXT_DIR;
               end else begin
                  row_q      <= row_d;
                  col_q      <= col_d;
                  mem_addr_q <= {1'b0, row_d, col_d};
                  state_q    <= S_READ_WAIT;
               end
            end
            S_READ_WAIT: state_q <= S_EVAL;
            S_EVAL: begin
               if (bus.mem_data_in == opp_col) begin
                  run_q   <= run_q + 3'd1;
                  state_q <= S_STEP;
               end else if (bus.mem_data_in == own_col && run_q != 3'd0) begin
                  mask_q[dir_q] <= 1'b1;
                  count_q       <= count_q + 6'(run_q);
                  sel_q         <= 1'b1;
                  ld_q          <= 1'b1;
                  step_q        <= dir_step;
                  sign_q        <= dir_sign;
                  state_q       <= S_LD_FLIP;
               end else begin
                  state_q <= S_NEXT_DIR;
               end
            end
            S_LD_FLIP: begin
               en_q    <= 1'b1;
               state_q <= S_EN_FLIP;
            end
            S_EN_FLIP: state_q <= S_WAIT_FLIP;
            S_WAIT_FLIP: begin
               if (bus.flip_done_in) begin
                  sel_q   <= 1'b0;
                  state_q <= S_NEXT_DIR;
               end
            end
            S_NEXT_DIR: begin
               if (dir_q == 3'(NDIR - 1)) begin
                  state_q <= S_DONE;
               end else begin
                  dir_q   <= dir_q + 3'd1;
                  state_q <= S_DIR_INIT;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               valid_q <= |mask_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_sel_o    = sel_q;
   assign bus.flip_ld_o    = ld_q;
   assign bus.flip_en_o    = en_q;
   assign bus.flip_addr_o  = origin_q;
   assign bus.flip_step_o  = step_q;
   assign bus.flip_sign_o  = sign_q;
   assign bus.flip_skip_o  = 1'b0;
   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.move_valid_o = valid_q;
   assign bus.dir_mask_o   = mask_q;
   assign bus.flip_count_o = count_q;
endmodule

// File: tb/tb_flip_sequencer.sv
// Directed and randomized moves against a ray-walking reference model with a
// one-cycle-latency board RAM and a flipper that answers after a random delay.
module tb_flip_sequencer;
   typedef struct packed {
      logic [6:0] addr;
      logic [4:0] step;
      logic       sign;
   } launch_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   flip_sequencer_if bus ();
   flip_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [1:0] board [64];
   int  prev_addr = 0;
   int  cnt = 0;
   int  en_cnt = 0;
   bit  flipping = 0, done_drv = 0, hold_done = 0, spur = 0, sel_ok = 1, addr_moved = 0;
   launch_t got_q[$];
   launch_t exp_q[$];
   int  r_lat;
   bit  r_seen;
   logic       r_valid;
   logic [7:0] r_mask;
   logic [5:0] r_count;
   logic [7:0] e_mask;
   int         e_count;
   int DR[8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
   int DC[8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: RAM returns data for the address presented a cycle earlier;
   // flipper records launches and pulses done a random 1..4 cycles after enable.
   task automatic tick();
      @(negedge clock);
      bus.mem_data_in  = board[prev_addr];
      prev_addr        = int'(bus.mem_addr_o[5:0]);
      bus.flip_done_in = 1'b0;
      if (done_drv) flipping = 0;
      done_drv = 0;
      if (bus.flip_ld_o === 1'b1) begin
         flipping = 1;
         got_q.push_back({bus.flip_addr_o, bus.flip_step_o, bus.flip_sign_o});
      end
      if (bus.flip_skip_o !== 1'b0) sel_ok = 0;
      if (bus.flip_en_o === 1'b1) begin
         if (!flipping) sel_ok = 0;
         en_cnt++;
         cnt = int'($urandom_range(1, 4));
      end else if (cnt > 0 && !hold_done) begin
         cnt--;
         if (cnt == 0) begin
            bus.flip_done_in = 1'b1;
            done_drv = 1;
         end
      end
      if (bus.mem_sel_o !== flipping) sel_ok = 0;
      if (spur && !flipping && $urandom_range(0, 7) == 0) bus.flip_done_in = 1'b1;
   endtask

   function automatic void ref_move(input int org, input int pl);
      int r, c, n, delta, own, opp;
      launch_t l;
      exp_q.delete();
      e_mask  = 8'h00;
      e_count = 0;
      if (org > 63) return;
      if (board[org] != 2'b00) return;
      own = pl ? 2 : 1;
      opp = pl ? 1 : 2;
      for (int d = 0; d < 8; d++) begin
         r = org / 8;
         c = org % 8;
         n = 0;
         while (1) begin
            r = r + DR[d];
            c = c + DC[d];
            if (r < 0 || r > 7 || c < 0 || c > 7) break;
            if (int'(board[r*8+c]) == opp) begin
               n++;
            end else begin
               if (int'(board[r*8+c]) == own && n > 0) begin
                  e_mask[d] = 1'b1;
                  e_count   = e_count + n;
                  delta     = DR[d] * 8 + DC[d];
                  l.addr    = 7'(org);
                  l.step    = 5'((delta < 0) ? -delta : delta);
                  l.sign    = (delta < 0);
                  exp_q.push_back(l);
               end
               break;
            end
         end
      end
   endfunction

   task automatic clear_board();
      for (int i = 0; i < 64; i++) board[i] = 2'b00;
   endtask

   task automatic run_move(input int org, input bit pl, input bit poke);
      logic [6:0] a0;
      int nmin;
      got_q.delete();
      en_cnt = 0;
      sel_ok = 1;
      r_seen = 0;
      r_lat  = 0;
      addr_moved = 0;
      a0 = bus.mem_addr_o;
      bus.start = 1'b1;
      bus.s_addr_in = 7'(org);
      bus.player = pl;
      for (int n = 1; n <= 4000; n++) begin
         if (poke && n == 5) begin
            bus.start = 1'b1;
            bus.s_addr_in = 7'($urandom);
            bus.player = 1'($urandom);
         end
         tick();
         if (n == 1 || (poke && n == 5)) begin
            bus.start = 1'b0;
            bus.s_addr_in = 7'($urandom);
            bus.player = 1'($urandom);
         end
         if (n == 1) chk("busy_after_start", bus.busy_o, 1);
         if (bus.mem_addr_o !== a0) addr_moved = 1;
         if (bus.done_o === 1'b1) begin
            r_seen = 1;
            r_lat  = n;
            break;
         end
      end
      chk("done_seen", r_seen, 1);
      r_valid = bus.move_valid_o;
      r_mask  = bus.dir_mask_o;
      r_count = bus.flip_count_o;
      chk("busy_at_done", bus.busy_o, 0);
      tick();
      chk("done_one_cycle", bus.done_o, 0);
      chk("results_hold", {bus.move_valid_o, bus.dir_mask_o, bus.flip_count_o}, {r_valid, r_mask, r_count});
      chk("launch_count", got_q.size(), exp_q.size());
      chk("enable_count", en_cnt, exp_q.size());
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) chk($sformatf("launch%0d", i), got_q[i], exp_q[i]);
      chk("mem_sel_window", sel_ok, 1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.player = 1'b0;
      bus.s_addr_in = '0;
      bus.mem_data_in = '0;
      bus.flip_done_in = 1'b0;
      clear_board();
      tick();
      tick();
      chk("reset_ctl", {bus.mem_sel_o, bus.flip_ld_o, bus.flip_en_o, bus.flip_sign_o, bus.flip_skip_o,
                        bus.busy_o, bus.done_o, bus.move_valid_o, bus.flip_step_o}, 0);
      chk("reset_data", {bus.mem_addr_o, bus.flip_addr_o, bus.dir_mask_o, bus.flip_count_o}, 0);
      reset = 1'b1;
      tick();

      // Standard opening, black plays 19: single capture downward.
      board[27] = 2'b10; board[28] = 2'b01; board[35] = 2'b01; board[36] = 2'b10;
      exp_q.delete();
      exp_q.push_back('{addr: 7'd19, step: 5'd8, sign: 1'b0});
      run_move(19, 0, 0);
      chk("open_valid", r_valid, 1);
      chk("open_mask", r_mask, 8'h40);
      chk("open_count", r_count, 1);

      // Occupied origin.
      exp_q.delete();
      run_move(27, 0, 0);
      chk("occ_fast", (r_lat <= 4), 1);
      chk("occ_valid", r_valid, 0);
      chk("occ_mask", r_mask, 0);

      // Reset while the flipper is running.
      got_q.delete();
      en_cnt = 0;
      hold_done = 1;
      bus.start = 1'b1; bus.s_addr_in = 7'd19; bus.player = 1'b0;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 200 && en_cnt == 0; i++) tick();
      chk("abort_reached_flip", en_cnt, 1);
      tick();
      tick();
      chk("abort_sel_before", bus.mem_sel_o, 1);
      reset = 1'b0;
      #1;
      chk("abort_ctl", {bus.mem_sel_o, bus.flip_ld_o, bus.flip_en_o, bus.flip_sign_o, bus.flip_skip_o,
                        bus.busy_o, bus.done_o, bus.move_valid_o, bus.flip_step_o}, 0);
      chk("abort_data", {bus.mem_addr_o, bus.flip_addr_o, bus.dir_mask_o, bus.flip_count_o}, 0);
      flipping = 0; done_drv = 0; cnt = 0; hold_done = 0;
      tick();
      chk("abort_no_done", bus.done_o, 0);
      reset = 1'b1;
      tick();
      tick();
      exp_q.delete();
      exp_q.push_back('{addr: 7'd19, step: 5'd8, sign: 1'b0});
      run_move(19, 0, 0);
      chk("after_rst_mask", r_mask, 8'h40);
      chk("after_rst_count", r_count, 1);

      // Row-end: the right-hand ray from column 7 must not wrap to the next row.
      clear_board();
      board[16] = 2'b10; board[17] = 2'b01;
      exp_q.delete();
      run_move(15, 0, 0);
      chk("wrap_valid", r_valid, 0);
      chk("wrap_mask", r_mask, 0);

      // White at the corner captures along d4 then d7.
      clear_board();
      board[1] = 2'b01; board[2] = 2'b01; board[3] = 2'b10;
      board[9] = 2'b01; board[18] = 2'b10;
      exp_q.delete();
      exp_q.push_back('{addr: 7'd0, step: 5'd1, sign: 1'b0});
      exp_q.push_back('{addr: 7'd0, step: 5'd9, sign: 1'b0});
      run_move(0, 1, 0);
      chk("multi_valid", r_valid, 1);
      chk("multi_mask", r_mask, 8'h90);
      chk("multi_count", r_count, 3);

      // Off-board address.
      exp_q.delete();
      run_move(64, 0, 0);
      chk("oob_latency", r_lat, 2);
      chk("oob_no_read", addr_moved, 0);
      chk("oob_valid", r_valid, 0);

      // Random boards, with stray done pulses and ignored starts mixed in.
      spur = 1;
      for (int it = 0; it < 40; it++) begin
         int org;
         bit pl;
         for (int i = 0; i < 64; i++) board[i] = 2'($urandom_range(0, 2));
         org = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 63));
         if (org < 64 && $urandom_range(0, 4) != 0) board[org] = 2'b00;
         pl = 1'($urandom);
         ref_move(org, int'(pl));
         run_move(org, pl, (org < 64) && (board[org] == 2'b00));
         chk($sformatf("rnd%0d_valid", it), r_valid, (e_mask != 0));
         chk($sformatf("rnd%0d_mask", it), r_mask, e_mask);
         chk($sformatf("rnd%0d_count", it), r_count, e_count);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/flip_sequencer.md
Name: flip_sequencer

Overview:
Move controller that sequences the flipper for one disc placement on the 8x8 board RAM. It scans all 8 directions from the placement cell and classifies each direction as capturing or not. For each capturing direction it loads and launches the flipper, then waits for the flipper's done pulse. It owns the board RAM read port during scanning and hands the RAM to the flipper through a select line while a flip is running.

Parameters:
NDIR, 8, number of scan directions (fixed; not meant to be overridden)
STEP_W, 5, width of the step value driven to the flipper

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to evaluate/play a move; ignored while busy
player  in  1  0 = black (own 2'b01, opponent 2'b10); 1 = white (own 2'b10, opponent 2'b01)
s_addr_in  in  7  placement cell, row*8+col; 0..63 legal
mem_data_in  in  2  board RAM read data (00 empty, 01 black, 10 white)
flip_done_in  in  1  flipper done pulse
mem_addr_o  out  7  sequencer read address to board RAM (registered)
mem_sel_o  out  1  1 = flipper drives RAM addr/wren/data; 0 = sequencer (read-only)
flip_ld_o  out  1  flipper load strobe
flip_en_o  out  1  flipper start strobe
flip_addr_o  out  7  flipper start address (= latched s_addr_in)
flip_step_o  out  5  flipper step magnitude: 9, 8, 7 or 1
flip_sign_o  out  1  1 = subtract step, 0 = add
flip_skip_o  out  1  held 0 (non-capturing directions are never launched)
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle completion pulse
move_valid_o  out  1  valid with done_o; 1 if any direction captured
dir_mask_o  out  8  capturing directions, bit d = direction d; valid with done_o
flip_count_o  out  6  total opponent discs captured; valid with done_o

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0, including mem_addr_o, dir_mask_o and flip_count_o. Assertion mid-operation aborts immediately; no done_o pulse. The flipper is reset by the same signal.
- Directions d0..d7 as (drow,dcol): d0(-1,-1) step9 sign1; d1(-1,0) 8/1; d2(-1,+1) 7/1; d3(0,-1) 1/1; d4(0,+1) 1/0; d5(+1,-1) 7/0; d6(+1,0) 8/0; d7(+1,+1) 9/0.
- Edge checks use 3-bit row/col counters plus a direction delta. A step whose row or col leaves 0..7 is an edge. Address arithmetic never wraps across rows.
- RAM read latency: mem_addr_o loads on the STEP edge, READ_WAIT idles one cycle, and EVAL samples mem_data_in.
- States:
  - IDLE: on start, latch s_addr_in and player; clear mask and count; busy_o=1. If s_addr_in[6]=1, go to DONE with move_valid_o=0. Otherwise set mem_addr_o=s_addr_in and go to ORG_WAIT.
  - ORG_WAIT -> ORG_EVAL: if the cell is non-empty, go to DONE (invalid). Otherwise d=0 and go to DIR_INIT.
  - DIR_INIT: row/col = origin; run_len=0; go to STEP.
  - STEP: if next cell is an edge, mark direction invalid and go to NEXT_DIR. Otherwise advance row/col, load mem_addr_o, and go to READ_WAIT, then EVAL.
  - EVAL:
    - opponent: run_len+1, go to STEP.
    - own with run_len>=1: set dir_mask bit d, flip_count += run_len, go to LD_FLIP.
    - own with run_len=0, or empty: go to NEXT_DIR.
  - LD_FLIP: mem_sel_o=1, flip_ld_o=1 for one cycle, with flip_addr_o, flip_step_o, flip_sign_o valid. Go to EN_FLIP.
  - EN_FLIP: flip_en_o=1 for one cycle. Go to WAIT_FLIP.
  - WAIT_FLIP: mem_sel_o=1 until the cycle flip_done_in=1 is seen. Then mem_sel_o=0 and go to NEXT_DIR. No timeout.
  - NEXT_DIR: if d=7 go to DONE, else d+1 and go to DIR_INIT.
  - DONE: done_o=1 for one cycle; busy_o=0; go to IDLE. move_valid_o, dir_mask_o and flip_count_o hold until the next accepted start.
- mem_sel_o is 1 only in LD_FLIP, EN_FLIP and WAIT_FLIP. Flipper-side addr/data/wren and their muxing are external.
- start while busy_o=1 is ignored; player and s_addr_in are sampled only at accept.
- flip_done_in outside WAIT_FLIP is ignored.
- The flipper also writes the origin cell on each launch; this is expected, since the value written is the same own colour each time.

Test Plan:
- Standard opening (27=10, 28=01, 35=01, 36=10, rest 00), player 0, s_addr_in=19 -> exactly one flipper launch with addr 19, step 8, sign 0. Done with move_valid_o=1, dir_mask_o=8'h40, flip_count_o=1. mem_sel_o high only during the flip.
- Same board, player 0, s_addr_in=27 (occupied) -> done_o within 4 cycles of start, move_valid_o=0, no flip_ld_o or flip_en_o.
- Edge wrap: player 0, 15=00, 16=10, 17=01 -> d4 (+1) rejected at the column-7 edge. move_valid_o=0, dir_mask_o=0.
- Multi-direction: player 1, origin 0, cells 1,2 = 01 and 3 = 10; cells 9 = 01 and 18 = 10 -> launches d4 then d7. dir_mask_o=8'h90, flip_count_o=3.
- s_addr_in=64 -> done_o two cycles after start, move_valid_o=0, no RAM reads.
- reset pulsed low during WAIT_FLIP -> all outputs 0 immediately, no done_o. A start issued 2 cycles later is accepted normally.
